// File: rtl/ofifo_pkg.sv
// Shared project constants for the systolic-array edge FIFOs.
// ofifo: output (psum) FIFO; ififo: input (activation) FIFO.
// Holds default sizing values only; no types are exported.
package ofifo_pkg;

    // Output FIFO defaults
    localparam int OFIFO_COL   = 8;   // array columns / independent lanes
    localparam int OFIFO_BW    = 16;  // psum width per lane
    localparam int OFIFO_DEPTH = 64;  // entries per lane (power of two, >= 4)

    // Input FIFO defaults
    localparam int IFIFO_ROW   = 8;
    localparam int IFIFO_BW    = 4;
    localparam int IFIFO_DEPTH = 64;

endpackage

// File: rtl/ofifo_lane.sv
// Single-lane, single-clock FIFO of depth x bw.
// Ports:
//   clk, reset      clock, async active-low reset
//   wr, in          write strobe / data (dropped when full)
//   rd              pop request (ignored when empty)
//   out             combinational head-of-queue data
//   o_empty, o_full occupancy flags, combinational from the pointers
module ofifo_lane
    import ofifo_pkg::*;
#(
    parameter int bw    = OFIFO_BW,
    parameter int depth = OFIFO_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic          rd,
    input  logic [bw-1:0] in,
    output logic [bw-1:0] out,
    output logic          o_empty,
    output logic          o_full
);

    localparam int AW = $clog2(depth);

    // One extra pointer bit distinguishes full from empty when the
    // address bits coincide.
    logic [AW:0]   wp, rp;
    logic [bw-1:0] mem [depth];
    logic          do_wr, do_rd;

    assign o_empty = (wp == rp);
    assign o_full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_wr   = wr && !o_full;
    assign do_rd   = rd && !o_empty;
    assign out     = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
        end
    end

    // Storage is not reset; pointer reset alone discards stale entries.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wp[AW-1:0]] <= in;
    end

endmodule

// File: rtl/ofifo.sv
// Output FIFO: col independent lanes written per-lane, read as whole rows.
// Ports:
//   clk, reset   clock, async active-low reset
//   wr[col]      per-lane write strobes; in = col packed bw-bit lanes
//   rd           row pop, honoured only when every lane holds data
//   out          registered popped row, holds when no read is accepted
//   o_valid      every lane non-empty
//   o_full       any lane full; o_ready = ~o_full
//   o_overflow   sticky: a write hit a full lane
module ofifo
    import ofifo_pkg::*;
#(
    parameter int col   = OFIFO_COL,
    parameter int bw    = OFIFO_BW,
    parameter int depth = OFIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [col-1:0]    wr,
    input  logic [col*bw-1:0] in,
    input  logic              rd,
    output logic [col*bw-1:0] out,
    output logic              o_valid,
    output logic              o_full,
    output logic              o_ready,
    output logic              o_overflow
);

    logic [col-1:0]    lane_empty, lane_full;
    logic [col*bw-1:0] head;
    logic              rd_ok;

    assign o_valid = ~|lane_empty;
    assign o_full  = |lane_full;
    assign o_ready = ~o_full;
    // Lanes pop only as a row, so a partial row is never consumed.
    assign rd_ok   = rd && o_valid;

    for (genvar g = 0; g < col; g++) begin : g_lane
        ofifo_lane #(.bw(bw), .depth(depth)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .wr      (wr[g]),
            .rd      (rd_ok),
            .in      (in[g*bw +: bw]),
            .out     (head[g*bw +: bw]),
            .o_empty (lane_empty[g]),
            .o_full  (lane_full[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out        <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (rd_ok) out <= head;
            // Full is sampled before the edge, so a pop on the same edge
            // does not rescue the write.
            if (|(wr & lane_full)) o_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ofifo.sv
module tb_ofifo;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int DEP = 64;
    localparam int W   = COL*BW;

    logic           clk = 1'b0;
    logic           reset;
    logic [COL-1:0] wr;
    logic [W-1:0]   din;
    logic           rd;
    logic [W-1:0]   dout;
    logic           o_valid, o_full, o_ready, o_overflow;

    int tests = 0;
    int fails = 0;

    ofifo #(.col(COL), .bw(BW), .depth(DEP)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr),
        .in         (din),
        .rd         (rd),
        .out        (dout),
        .o_valid    (o_valid),
        .o_full     (o_full),
        .o_ready    (o_ready),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    // Row whose lane i holds base+i.
    function automatic logic [W-1:0] row(input int base);
        logic [W-1:0] r;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = 16'(base + i);
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle, then sample 1 time unit after the edge.
    task automatic cyc(input logic [COL-1:0] w, input int base, input logic r);
        wr  = w;
        din = row(base);
        rd  = r;
        @(posedge clk);
        #1;
        wr = '0;
        rd = 1'b0;
    endtask

    task automatic do_reset();
        wr = '0; rd = 1'b0; din = '0;
        reset = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    typedef struct {
        logic [COL-1:0] wr;
        int             base;
        logic           rd;
        logic           ev;
        logic           ef;
        logic           eo;
        logic [W-1:0]   eout;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [W-1:0] exp_row;

        // Staggered writes assemble one row; read pops it; an empty read is ignored.
        for (int i = 0; i < 8; i++)
            tbl[i] = '{wr: 8'(1 << i), base: 'h100, rd: 1'b0,
                       ev: (i == 7), ef: 1'b0, eo: 1'b0, eout: '0};
        tbl[8] = '{wr: 8'h00, base: 0, rd: 1'b1, ev: 1'b0, ef: 1'b0, eo: 1'b0, eout: row('h100)};
        tbl[9] = '{wr: 8'h00, base: 0, rd: 1'b1, ev: 1'b0, ef: 1'b0, eo: 1'b0, eout: row('h100)};

        // Reset state, checked while reset is held and after release
        wr = '0; rd = 1'b0; din = '0; reset = 1'b0;
        #1;
        chk("rst_valid", W'(o_valid), W'(0));
        chk("rst_out",   dout,        '0);
        @(posedge clk); #1;
        reset = 1'b1;
        cyc('0, 0, 1'b0);
        chk("idle_valid", W'(o_valid),    W'(0));
        chk("idle_full",  W'(o_full),     W'(0));
        chk("idle_ready", W'(o_ready),    W'(1));
        chk("idle_out",   dout,           '0);
        chk("idle_ovf",   W'(o_overflow), W'(0));

        // Table-driven staggered sequence
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].wr, tbl[i].base, tbl[i].rd);
            chk($sformatf("vec%0d_valid", i), W'(o_valid),    W'(tbl[i].ev));
            chk($sformatf("vec%0d_full", i),  W'(o_full),     W'(tbl[i].ef));
            chk($sformatf("vec%0d_ovf", i),   W'(o_overflow), W'(tbl[i].eo));
            chk($sformatf("vec%0d_out", i),   dout,           tbl[i].eout);
        end

        // Fill all 64 rows, then overflow
        do_reset();
        for (int k = 0; k < DEP; k++) begin
            chk("fill_not_full", W'(o_full), W'(0));
            cyc(8'hFF, k*16, 1'b0);
        end
        chk("full_full",  W'(o_full),     W'(1));
        chk("full_ready", W'(o_ready),    W'(0));
        chk("full_ovf0",  W'(o_overflow), W'(0));
        cyc(8'hFF, 'hF000, 1'b0);
        chk("ovf_set",    W'(o_overflow), W'(1));
        chk("ovf_full",   W'(o_full),     W'(1));
        for (int k = 0; k < DEP; k++) begin
            cyc('0, 0, 1'b1);
            chk($sformatf("drain%0d", k), dout, row(k*16));
        end
        chk("drain_valid", W'(o_valid),    W'(0));
        chk("drain_full",  W'(o_full),     W'(0));
        chk("drain_ovf",   W'(o_overflow), W'(1));

        // Wrap: occupancy 3, 100 cycles of simultaneous write+read
        do_reset();
        for (int k = 0; k < 3; k++) cyc(8'hFF, k*16, 1'b0);
        for (int k = 0; k < 100; k++) begin
            cyc(8'hFF, (k+3)*16, 1'b1);
            chk($sformatf("wrap%0d_out", k), dout, row(k*16));
            chk($sformatf("wrap%0d_valid", k), W'(o_valid), W'(1));
        end
        for (int k = 100; k < 103; k++) begin
            cyc('0, 0, 1'b1);
            chk($sformatf("wrap_tail%0d", k), dout, row(k*16));
        end
        chk("wrap_empty", W'(o_valid),    W'(0));
        chk("wrap_ovf",   W'(o_overflow), W'(0));

        // Lane 5 empty: read must be ignored
        do_reset();
        cyc(8'hFF, 'h2000, 1'b0);
        cyc('0, 0, 1'b1);
        chk("l5_first", dout, row('h2000));
        cyc(8'hDF, 'h3000, 1'b0);
        cyc(8'hDF, 'h3010, 1'b0);
        cyc('0, 0, 1'b1);
        chk("l5_out_hold", dout,           row('h2000));
        chk("l5_valid",    W'(o_valid),    W'(0));
        chk("l5_ovf",      W'(o_overflow), W'(0));
        cyc(8'h20, 'h4000, 1'b0);
        chk("l5_valid_up", W'(o_valid), W'(1));
        cyc('0, 0, 1'b1);
        exp_row = row('h3000);
        exp_row[5*BW +: BW] = 16'h4005;
        chk("l5_row", dout, exp_row);

        // Reset mid-operation with 10 rows stored
        do_reset();
        for (int k = 0; k < 10; k++) cyc(8'hFF, 'h5000 + k*16, 1'b0);
        cyc('0, 0, 1'b1);
        chk("mid_pre_out", dout, row('h5000));
        #2 reset = 1'b0;
        #1;
        chk("mid_valid", W'(o_valid), W'(0));
        chk("mid_out",   dout,        '0);
        @(posedge clk); #1;
        reset = 1'b1;
        cyc(8'hFF, 'h6000, 1'b0);
        chk("mid_new_valid", W'(o_valid), W'(1));
        cyc('0, 0, 1'b1);
        chk("mid_new_row",   dout,        row('h6000));
        chk("mid_new_empty", W'(o_valid), W'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ofifo.md
OFIFO -- requirements
Module: ofifo

Interface
REQ-001 SHALL have parameter col, default 8, meaning number of array columns (independent lanes).
REQ-002 SHALL have parameter bw, default 16, meaning bits per lane (psum width).
REQ-003 SHALL have parameter depth, default 64, meaning entries per lane; power of two, at least 4.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous active-low reset (0 = reset asserted).
REQ-006 SHALL have port wr, input, col bits, per-lane write strobe; bit i writes lane i.
REQ-007 SHALL have port in, input, col*bw bits, write data; lane i occupies bits [bw*(i+1)-1 : bw*i].
REQ-008 SHALL have port rd, input, 1 bit, row read request (pops all lanes together).
REQ-009 SHALL have port out, output, col*bw bits, registered read row; lane packing as in.
REQ-010 SHALL have port o_valid, output, 1 bit, high when every lane is non-empty (a full row is available).
REQ-011 SHALL have port o_full, output, 1 bit, high when any lane is full.
REQ-012 SHALL have port o_ready, output, 1 bit, exact inverse of o_full.
REQ-013 SHALL have port o_overflow, output, 1 bit, sticky error flag.

Function
REQ-014 Per lane: write accepted when wr[i]=1 and lane i not full; data stored at the lane write pointer, pointer +1 modulo depth.
REQ-015 Lanes write independently; staggered writes (lane i one cycle after lane i-1) SHALL assemble into aligned rows.
REQ-016 Row read accepted when rd=1 and o_valid=1; all lanes pop one entry on the same edge.
REQ-017 Read latency: out SHALL hold the popped row from the edge that accepts the read; out holds its value when no read is accepted.
REQ-018 rd while o_valid=0 SHALL be ignored: no pointer change, out unchanged, no error.
REQ-019 wr[i] to a full lane SHALL be dropped (no pointer or data change) and SHALL set o_overflow, which stays 1 until reset.
REQ-020 Simultaneous accepted read and write on a lane: occupancy unchanged; both pointers advance; a full lane that is also popped SHALL still drop the write (full is evaluated before the edge).
REQ-021 Pointers SHALL be log2(depth)+1 bits; empty = pointers equal; full = MSBs differ and lower bits equal; wrap-around SHALL be seamless.
REQ-022 o_valid, o_full and o_ready SHALL be combinational from the current pointers (no extra cycle).

Reset
REQ-023 While reset=0: all pointers 0, out=0, o_overflow=0; hence o_valid=0, o_full=0, o_ready=1.
REQ-024 Reset asserted mid-operation SHALL discard all stored data immediately; storage contents need not be cleared.
REQ-025 The first write is accepted on the first rising edge after reset deasserts.

Structure
REQ-026 SHALL use one sub-module, ofifo_lane: single-clock FIFO of depth x bw with wr, rd, in, out, o_empty, o_full, instantiated col times.
REQ-027 Default col, bw and depth values SHALL live in the shared project package alongside the ififo constants; no typedefs are needed.
REQ-028 Row-level logic (valid AND-reduce, full OR-reduce, overflow flag, read qualification) SHALL be in ofifo.

Verification
REQ-029 Reset, then idle -> o_valid=0, o_full=0, o_ready=1, out=0, o_overflow=0.
REQ-030 Staggered write: wr=0x01, 0x02, 0x04 ... 0x80 on consecutive cycles, with lane i data 0x0100+i -> o_valid rises only after the lane-7 write; rd=1 -> out lane i = 0x0100+i; o_valid falls.
REQ-031 Write 64 rows with wr=0xFF -> o_full=1, o_ready=0; 65th write -> data dropped, o_overflow=1; 64 reads return rows 0..63 in order.
REQ-032 Wrap: 100 cycles of simultaneous wr=0xFF and rd=1 with occupancy 3 -> occupancy stays 3, data in order across pointer wrap.
REQ-033 rd=1 with lane 5 empty and others holding 2 entries -> no pop, out unchanged, o_overflow unchanged.
REQ-034 Assert reset with 10 rows stored -> o_valid=0 immediately; after release, a new row is read back correctly with no stale data.
